// File: rtl/cc_dmem_pkg.sv
// Shared definitions for the central controller data RAM path: widths, depth and
// the access-controller state encoding used by dram wrapper, execute and dmem_access_ctrl.
package cc_dmem_pkg;

    localparam int DMEM_ADDR_W = 11;
    localparam int DMEM_DATA_W = 64;
    localparam int DMEM_TAG_W  = 5;
    localparam int DMEM_DEPTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } dmem_state_e;

endpackage

// File: rtl/dmem_access_ctrl.sv
// Load/store front end for the CC data RAM: one request at a time, registered RAM strobes,
// held load response. Define DMEM_ADDR_CHECK_EN to drop accesses at or beyond MEM_DEPTH.
module dmem_access_ctrl
    import cc_dmem_pkg::*;
#(
    parameter int ADDR_W    = DMEM_ADDR_W,
    parameter int DATA_W    = DMEM_DATA_W,
    parameter int TAG_W     = DMEM_TAG_W,
    parameter int MEM_DEPTH = DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and the payload is sampled only on that edge.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err,
    output logic              st_err,
    output logic              mem_en,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    dmem_state_e state, state_d;

    logic             we_q;
    logic             oor_q;
    logic [TAG_W-1:0] tag_q;

    logic              accept;
    logic              req_oor;
    logic              capture;
    logic              req_ready_d;
    logic              rsp_valid_d;
    logic              st_err_d;
    logic              mem_en_d;
    logic              mem_re_d;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;

    // req_ready is registered, so it is already 0 in the cycle after every acceptance.
    assign accept = req_valid && req_ready;

`ifdef DMEM_ADDR_CHECK_EN
    assign req_oor = 32'(req_addr) >= 32'(MEM_DEPTH);
`else
    logic unused_depth;
    assign req_oor      = 1'b0;
    assign unused_depth = (MEM_DEPTH > 0);
`endif

    always_comb begin
        state_d     = state;
        req_ready_d = 1'b0;
        rsp_valid_d = rsp_valid;
        st_err_d    = 1'b0;
        capture     = 1'b0;
        mem_en_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_ISSUE;
                    mem_en_d    = !req_oor;
                    mem_we_d    = req_we && !req_oor;
                    mem_re_d    = !req_we && !req_oor;
                    mem_addr_d  = req_addr;
                    mem_wdata_d = req_wdata;
                    st_err_d    = req_we && req_oor;
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d     = ST_IDLE;
                    req_ready_d = 1'b1;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // RAM read data is valid now, one cycle after the read strobe.
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                capture     = 1'b1;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
            rsp_err   <= 1'b0;
            st_err    <= 1'b0;
            mem_en    <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            we_q      <= 1'b0;
            oor_q     <= 1'b0;
            tag_q     <= '0;
        end else begin
            state     <= state_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            st_err    <= st_err_d;
            mem_en    <= mem_en_d;
            mem_re    <= mem_re_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if (accept) begin
                we_q  <= req_we;
                oor_q <= req_oor;
                tag_q <= req_tag;
            end
            if (capture) begin
                rsp_data <= oor_q ? '0 : mem_rdata;
                rsp_tag  <= tag_q;
                rsp_err  <= oor_q;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl with a behavioural dram model; covers both builds
// (DMEM_ADDR_CHECK_EN defined or not).
module tb_dmem_access_ctrl;
    import cc_dmem_pkg::*;

    localparam int AW = 11;
    localparam int DW = 64;
    localparam int TW = 5;
    localparam int DEPTH = 16;
    localparam int RSP_W = DW + TW + 1;
`ifdef DMEM_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [TW-1:0] req_tag;
    logic          rsp_valid, rsp_ready, rsp_err, st_err;
    logic [DW-1:0] rsp_data;
    logic [TW-1:0] rsp_tag;
    logic          mem_en, mem_re, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;
    logic [RSP_W-1:0] exp_q[$];
    logic [DW-1:0] exp_mem [0:2047];

    dmem_access_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err), .st_err(st_err),
        .mem_en(mem_en), .mem_re(mem_re), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- dram model ----------------
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {32'hC0DE_CAFE, 21'd0, a};
    endfunction

    logic [DW-1:0] ram [0:2047];
    logic [2047:0] ram_wr = '0;
    logic [DW-1:0] ram_q = '0;
    logic [DW-1:0] junk = '0;
    logic          rd_vld = 1'b0;

    always @(posedge clk) begin
        junk   <= {$urandom, $urandom};
        rd_vld <= mem_en && mem_re;
        if (mem_en && mem_we) begin
            ram[mem_addr]    <= mem_wdata;
            ram_wr[mem_addr] <= 1'b1;
        end
        if (mem_en && mem_re)
            ram_q <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
    end
    // Outside the read-data cycle the model returns noise.
    assign mem_rdata = rd_vld ? ram_q : junk;

    // ---------------- strobe monitor ----------------
    int cyc = 0;
    int wr_cnt = 0;
    int en_cnt = 0;
    int wr_cyc[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) en_cnt <= en_cnt + 1;
        if (mem_en && mem_we) begin
            wr_cnt <= wr_cnt + 1;
            wr_cyc.push_back(cyc);
        end
    end

    // ---------------- checking / driver tasks ----------------
    task automatic check(input string name, input logic [RSP_W-1:0] act, input logic [RSP_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered just after a negedge; returns just after the negedge following acceptance (ISSUE).
    task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [TW-1:0] tag);
        int n = 0;
        req_we = we; req_addr = addr; req_wdata = wdata; req_tag = tag; req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_we = $urandom_range(0, 1);
        req_addr = AW'($urandom_range(0, 2047));
        req_wdata = {$urandom, $urandom};
        req_tag = TW'($urandom_range(0, 31));
    endtask

    task automatic store_op(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bit oor;
        oor = CHK && (addr >= AW'(DEPTH));
        send(1'b1, addr, data, '0);
        check("st_issue_en", mem_en, !oor);
        check("st_issue_we", mem_we, !oor);
        check("st_issue_re", mem_re, 1'b0);
        check("st_issue_addr", mem_addr, addr);
        check("st_issue_wdata", mem_wdata, data);
        check("st_issue_err", st_err, oor);
        check("st_issue_ready", req_ready, 1'b0);
        if (!oor) exp_mem[addr] = data;
        @(negedge clk);
        check("st_done_we", mem_we, 1'b0);
        check("st_done_en", mem_en, 1'b0);
        check("st_done_err", st_err, 1'b0);
        check("st_done_ready", req_ready, 1'b1);
    endtask

    task automatic load_op(input logic [AW-1:0] addr, input logic [TW-1:0] tag, input int hold);
        bit oor;
        logic [DW-1:0] exp_d;
        logic [RSP_W-1:0] e;
        oor = CHK && (addr >= AW'(DEPTH));
        exp_d = oor ? '0 : exp_mem[addr];
        exp_q.push_back({exp_d, tag, oor});
        send(1'b0, addr, '0, tag);
        check("ld_issue_en", mem_en, !oor);
        check("ld_issue_re", mem_re, !oor);
        check("ld_issue_we", mem_we, 1'b0);
        check("ld_issue_addr", mem_addr, addr);
        check("ld_issue_ready", req_ready, 1'b0);
        @(negedge clk);
        check("ld_lat_early", rsp_valid, 1'b0);
        check("ld_capture_en", mem_en, 1'b0);
        @(negedge clk);
        check("ld_lat_valid", rsp_valid, 1'b1);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL ld_sb_empty: got no expected entry expected one");
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check("ld_rsp", {rsp_data, rsp_tag, rsp_err}, e);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1'b1);
            check("bp_stable", {rsp_data, rsp_tag, rsp_err}, e);
            check("bp_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("ld_done_valid", rsp_valid, 1'b0);
        check("ld_done_ready", req_ready, 1'b1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        int            hold;
    } vec_t;

    vec_t vecs[10];
    logic [DW-1:0] bb[16];
    int w0;
    int e0;

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_tag = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 2048; i++) exp_mem[i] = init_val(AW'(i));

        vecs[0] = '{1'b1, 11'd10, 64'h0123_4567_89AB_CDEF, 5'd0,  0};
        vecs[1] = '{1'b1, 11'd11, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0,  0};
        vecs[2] = '{1'b0, 11'd10, 64'h0,                   5'd1,  0};
        vecs[3] = '{1'b0, 11'd11, 64'h0,                   5'd31, 2};
        vecs[4] = '{1'b0, 11'd9,  64'h0,                   5'd4,  0};
        vecs[5] = '{1'b1, 11'd10, 64'h0,                   5'd0,  0};
        vecs[6] = '{1'b0, 11'd10, 64'h0,                   5'd12, 1};
        vecs[7] = '{1'b1, 11'd15, 64'h5555_AAAA_0F0F_F0F0, 5'd0,  0};
        vecs[8] = '{1'b0, 11'd15, 64'h0,                   5'd0,  0};
        vecs[9] = '{1'b0, 11'd3,  64'h0,                   5'd22, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ctrl", {req_ready, rsp_valid, rsp_err, st_err, mem_en, mem_re, mem_we}, '0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_wdata", mem_wdata, '0);
        check("rst_rsp", {rsp_data, rsp_tag}, '0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_release_ready", req_ready, 1'b1);

        // Store then load, with 5 cycles of response backpressure
        w0 = wr_cnt;
        store_op(11'd3, 64'hDEAD_BEEF_0123_4567);
        check("st_one_write", wr_cnt - w0, 1);
        load_op(11'd3, 5'd7, 5);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].we) store_op(vecs[i].addr, vecs[i].data);
            else            load_op(vecs[i].addr, vecs[i].tag, vecs[i].hold);
        end

        // Back-to-back stores with req_valid held high
        w0 = wr_cnt;
        wr_cyc.delete();
        for (int i = 0; i < 16; i++) begin
            int n = 0;
            bb[i] = {$urandom, $urandom};
            req_we = 1'b1; req_addr = AW'(i); req_wdata = bb[i]; req_tag = '0; req_valid = 1'b1;
            while (!req_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            @(negedge clk);
            exp_mem[i] = bb[i];
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_writes", wr_cnt - w0, 16);
        check("b2b_cyc_count", wr_cyc.size(), 16);
        for (int i = 1; i < 16 && i < wr_cyc.size(); i++)
            check("b2b_gap", wr_cyc[i] - wr_cyc[i-1], 2);
        for (int i = 0; i < 16; i++) load_op(AW'(i), TW'(i), 0);

        // Reset during the ISSUE cycle of a store
        w0 = wr_cnt;
        send(1'b1, 11'd5, 64'h1, '0);
        check("rst_issue_we_pre", mem_we, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rst_issue_we_async", mem_we, 1'b0);
        check("rst_issue_en_async", mem_en, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        check("rst_issue_rsp_valid", rsp_valid, 1'b0);
        check("rst_issue_no_write", wr_cnt - w0, 0);
        load_op(11'd5, 5'd9, 0);

        // Reset while a load response is held
        send(1'b0, 11'd4, '0, 5'd9);
        @(negedge clk);
        @(negedge clk);
        check("rst_held_pre", rsp_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rst_held_drop", rsp_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_held_after", {rsp_valid, req_ready}, 2'b01);

        // Address range behaviour (build dependent)
        e0 = en_cnt;
        load_op(11'd16, 5'd3, 0);
        check("oor_ld_en_count", en_cnt - e0, CHK ? 0 : 1);
        store_op(11'd2047, 64'h0BAD_0BAD_0BAD_0BAD);
        check("oor_st_ram", ram_wr[2047], !CHK);
        load_op(11'd2047, 5'd30, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
